// File: rtl/usb_crc_engine.sv
// Serial USB CRC5/CRC16 engine: checks the RX residue and emits the
// inverted CRC field MSb-first on TX. Ports: clk, n_rst, crc_clear,
// crc_sel, shift_enable, d_orig, gen_start, tx_ready -> tx_bit,
// tx_valid, tx_done, crc_ok, crc_value[15:0], mode.
module usb_crc_engine #(
  parameter logic [4:0]  POLY5  = 5'h05,
  parameter logic [4:0]  RES5   = 5'h0C,
  parameter logic [15:0] POLY16 = 16'h8005,
  parameter logic [15:0] RES16  = 16'h800D
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        crc_clear,
  input  logic        crc_sel,
  input  logic        shift_enable,
  input  logic        d_orig,
  input  logic        gen_start,
  input  logic        tx_ready,
  output logic        tx_bit,
  output logic        tx_valid,
  output logic        tx_done,
  output logic        crc_ok,
  output logic [15:0] crc_value,
  output logic        mode
);

  typedef enum logic {
    ACCUM = 1'b0,
    SEND  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_n;
  logic [15:0] r_q;
  logic [15:0] w_q_n;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_n;
  logic        r_mode;
  logic        w_mode_n;
  logic        r_done;
  logic        w_done_n;

  logic [15:0] w_mask;
  logic [15:0] w_poly;
  logic [15:0] w_shl;
  logic [3:0]  w_last;
  logic        w_msb;
  logic        w_fb;

  // Mask doubles as the INIT value: all ones over the active width.
  assign w_mask = r_mode ? 16'hFFFF : 16'h001F;
  assign w_poly = r_mode ? POLY16 : {11'd0, POLY5};
  assign w_msb  = r_mode ? r_q[15] : r_q[4];
  assign w_last = r_mode ? 4'd15 : 4'd4;
  assign w_shl  = {r_q[14:0], 1'b0} & w_mask;
  assign w_fb   = d_orig ^ w_msb;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= ACCUM;
      r_q     <= 16'h001F;
      r_cnt   <= 4'd0;
      r_mode  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_q     <= w_q_n;
      r_cnt   <= w_cnt_n;
      r_mode  <= w_mode_n;
      r_done  <= w_done_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_q_n     = r_q;
    w_cnt_n   = r_cnt;
    w_mode_n  = r_mode;
    w_done_n  = 1'b0;
    if (crc_clear) begin
      w_q_n     = crc_sel ? 16'hFFFF : 16'h001F;
      w_mode_n  = crc_sel;
      w_state_n = ACCUM;
      w_cnt_n   = 4'd0;
    end else begin
      case (r_state)
        ACCUM: begin
          // A shift in the gen_start cycle lands first, so SEND
          // emits the fully updated register.
          if (shift_enable)
            w_q_n = w_shl ^ (w_fb ? w_poly : 16'h0000);
          if (gen_start) begin
            w_state_n = SEND;
            w_cnt_n   = 4'd0;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (r_cnt == w_last) begin
              w_state_n = ACCUM;
              w_q_n     = w_mask;
              w_cnt_n   = 4'd0;
              w_done_n  = 1'b1;
            end else begin
              w_q_n   = w_shl;
              w_cnt_n = r_cnt + 4'd1;
            end
          end
        end
        default: w_state_n = ACCUM;
      endcase
    end
  end

  assign tx_valid  = (r_state == SEND);
  assign tx_bit    = (r_state == SEND) ? ~w_msb : 1'b0;
  assign tx_done   = r_done;
  assign crc_value = r_q;
  assign mode      = r_mode;

  always_comb begin
    crc_ok = 1'b0;
    if (r_state == ACCUM)
      crc_ok = r_mode ? (r_q == RES16) : (r_q[4:0] == RES5);
  end

endmodule
